conway_gen_ctrl: RTL and testbench

- Generation sequencer for the Game of Life board memory.
- Sweeps every cell of the current bank, reads its 9-cell toroidal neighbourhood, applies the Life rule, and writes the result into the other bank. It swaps banks only during vertical blank so the display never tears.
- Shares the single board read port between the VGA pixel fetch (priority) and the update engine.
- Also sequences whole-board clear and LFSR seed passes.

---
 rtl/conway_gen_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_conway_gen_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conway_gen_ctrl.sv
// Game of Life generation sequencer: sweeps the displayed bank, writes the next generation
// into the other bank, swaps banks in vblank, and runs whole-board clear/seed passes.
module conway_gen_ctrl #(
   parameter int COLS = 32,
   parameter int ROWS = 24,
   parameter int CW   = 5,
   parameter int RW   = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 step,
   input  logic                 gen_tick,
   input  logic                 clear,
   input  logic                 seed,
   input  logic                 vblank,
   input  logic                 vga_req,
   input  logic [RW+CW-1:0]     vga_addr,
   output logic                 vga_data,
   output logic                 vga_valid,
   output logic                 rd_en,
   output logic [RW+CW:0]       rd_addr,
   input  logic                 rd_data,
   output logic                 wr_en,
   output logic [RW+CW:0]       wr_addr,
   output logic                 wr_data,
   output logic                 cur_bank,
   output logic [15:0]          gen_count,
   output logic                 busy,
   output logic [2:0]           state_o
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_READ      = 3'd1,
      S_ACC       = 3'd2,
      S_WRITE     = 3'd3,
      S_SWAP_WAIT = 3'd4,
      S_INIT      = 3'd5
   } state_t;

   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

   state_t        state;
   state_t        state_nx;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic [3:0]    k;
   logic [3:0]    count;
   logic          center;
   logic          init_pass;
   logic          init_clear;
   logic [15:0]   lfsr;
   logic          tag_vga;
   logic          tag_eng;
   logic          tag_center;
   logic          vga_hold;

   logic          eng_issue;
   logic          last_cell;
   logic          start_gen;
   logic          start_init;

   function automatic logic [RW-1:0] nbr_row(input logic [RW-1:0] r, input logic [3:0] kk);
      logic [RW-1:0] res;
      res = r;
      if (kk < 4'd3)
         res = (r == '0) ? LAST_ROW : r - 1'b1;
      else if (kk > 4'd5)
         res = (r == LAST_ROW) ? '0 : r + 1'b1;
      return res;
   endfunction

   // COLS is a power of two, so column wrap falls out of the index width.
   function automatic logic [CW-1:0] nbr_col(input logic [CW-1:0] c, input logic [3:0] kk);
      logic [CW-1:0] res;
      res = c;
      case (kk)
         4'd0, 4'd3, 4'd6: res = c - 1'b1;
         4'd2, 4'd5, 4'd8: res = c + 1'b1;
         default:          res = c;
      endcase
      return res;
   endfunction

   function automatic logic life_rule(input logic ctr, input logic [3:0] n);
      return (n == 4'd3) | (ctr & (n == 4'd2));
   endfunction

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   assign eng_issue  = (state == S_READ) & ~vga_req;
   assign last_cell  = (row == LAST_ROW) & (col == LAST_COL);
   assign start_gen  = step | (run & gen_tick);
   assign start_init = clear | seed;

   assign vga_valid = tag_vga;
   assign vga_data  = tag_vga ? rd_data : vga_hold;
   assign busy      = (state != S_IDLE);
   assign state_o   = state;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start_init)
               state_nx = S_INIT;
            else if (start_gen)
               state_nx = S_READ;
         end
         S_READ:      if (eng_issue && k == 4'd8) state_nx = S_ACC;
         S_ACC:       state_nx = S_WRITE;
         S_WRITE:     state_nx = last_cell ? S_SWAP_WAIT : S_READ;
         S_INIT:      if (last_cell) state_nx = S_SWAP_WAIT;
         S_SWAP_WAIT: if (vblank) state_nx = S_IDLE;
         default:     state_nx = S_IDLE;
      endcase
   end

   // The display always wins the read port; the engine only issues on cycles it is free.
   always_comb begin
      rd_en   = vga_req | (state == S_READ);
      rd_addr = '0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = 1'b0;
      if (vga_req)
         rd_addr = {cur_bank, vga_addr};
      else if (state == S_READ)
         rd_addr = {cur_bank, nbr_row(row, k), nbr_col(col, k)};
      case (state)
         S_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = {~cur_bank, row, col};
            wr_data = life_rule(center, count);
         end
         S_INIT: begin
            wr_en   = 1'b1;
            wr_addr = {~cur_bank, row, col};
            wr_data = init_clear ? 1'b0 : lfsr[0];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         row        <= '0;
         col        <= '0;
         k          <= '0;
         count      <= '0;
         center     <= 1'b0;
         cur_bank   <= 1'b0;
         gen_count  <= '0;
         init_pass  <= 1'b0;
         init_clear <= 1'b0;
         lfsr       <= 16'hACE1;
         tag_vga    <= 1'b0;
         tag_eng    <= 1'b0;
         tag_center <= 1'b0;
         vga_hold   <= 1'b0;
      end else begin
         state      <= state_nx;
         tag_vga    <= vga_req;
         tag_eng    <= eng_issue;
         tag_center <= (k == 4'd4);
         if (tag_vga)
            vga_hold <= rd_data;
         if (tag_eng) begin
            if (tag_center)
               center <= rd_data;
            else
               count <= count + {3'b000, rd_data};
         end
         case (state)
            S_IDLE: begin
               row    <= '0;
               col    <= '0;
               k      <= '0;
               count  <= '0;
               center <= 1'b0;
               if (start_init)
                  init_clear <= clear;
               else if (start_gen)
                  init_pass <= 1'b0;
            end
            S_READ: begin
               if (eng_issue)
                  k <= (k == 4'd8) ? 4'd0 : k + 4'd1;
            end
            S_WRITE: begin
               k      <= '0;
               count  <= '0;
               center <= 1'b0;
               col    <= col + 1'b1;
               if (col == LAST_COL)
                  row <= (row == LAST_ROW) ? '0 : row + 1'b1;
            end
            S_INIT: begin
               col <= col + 1'b1;
               if (col == LAST_COL)
                  row <= (row == LAST_ROW) ? '0 : row + 1'b1;
               if (!init_clear)
                  lfsr <= lfsr_next(lfsr);
               if (last_cell)
                  init_pass <= 1'b1;
            end
            S_SWAP_WAIT: begin
               if (vblank) begin
                  cur_bank  <= ~cur_bank;
                  gen_count <= init_pass ? 16'd0 : gen_count + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conway_gen_ctrl.sv
// Bench for conway_gen_ctrl on an 8x8 torus: a behavioural board memory, a table of known
// patterns, random boards against a plain Life model, and hand-written corner sequences.
module tb_conway_gen_ctrl;
   localparam int COLS = 8;
   localparam int ROWS = 8;
   localparam int CW   = 3;
   localparam int RW   = 3;
   localparam int NC   = COLS * ROWS;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             run = 1'b0, step = 1'b0, gen_tick = 1'b0, clear = 1'b0, seed = 1'b0;
   logic             vblank = 1'b0, vga_req = 1'b0;
   logic [RW+CW-1:0] vga_addr = '0;
   logic             vga_data, vga_valid, rd_en, rd_data, wr_en, wr_data, cur_bank, busy;
   logic [RW+CW:0]   rd_addr, wr_addr;
   logic [15:0]      gen_count;
   logic [2:0]       state_o;

   int n_chk = 0;
   int n_fail = 0;

   logic             mem [0:2*NC-1];
   int               wr_cnt = 0;
   logic             load_req = 1'b0;
   logic             load_bank = 1'b0;
   logic [NC-1:0]    load_board = '0;

   typedef struct {
      logic [NC-1:0] cur;
      logic [NC-1:0] nxt;
   } vec_t;
   vec_t tbl [4];

   logic          exp_bank = 1'b0;
   logic [15:0]   exp_gen = 16'd0;
   logic [15:0]   lfsr_m = 16'hACE1;
   logic [NC-1:0] res, rb, sb;
   int            span, nwr, w0, cell_cyc;
   bit            wr_seen;
   logic          vq [$];
   logic [5:0]    addrs [5] = '{6'd17, 6'd0, 6'd18, 6'd5, 6'd19};

   always #5 clk = ~clk;

   conway_gen_ctrl #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .gen_tick(gen_tick),
      .clear(clear), .seed(seed), .vblank(vblank), .vga_req(vga_req),
      .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .cur_bank(cur_bank),
      .gen_count(gen_count), .busy(busy), .state_o(state_o)
   );

   // Board memory: one-cycle read latency; idle read cycles return noise.
   always @(posedge clk) begin
      rd_data <= rd_en ? mem[rd_addr] : 1'($urandom);
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
         wr_cnt <= wr_cnt + 1;
      end
      if (load_req)
         for (int i = 0; i < NC; i++) mem[{load_bank, 6'(i)}] <= load_board[i];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NC-1:0] life_model(input logic [NC-1:0] b);
      logic [NC-1:0] nx;
      int n;
      nx = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if (dr != 0 || dc != 0)
                     n += int'(b[((r + dr + ROWS) % ROWS) * COLS + (c + dc + COLS) % COLS]);
            nx[r*COLS + c] = (n == 3) || (b[r*COLS + c] && n == 2);
         end
      return nx;
   endfunction

   task automatic seed_model(input logic [15:0] s_in, output logic [NC-1:0] b, output logic [15:0] s_out);
      logic [15:0] s;
      s = s_in;
      for (int i = 0; i < NC; i++) begin
         b[i] = s[0];
         s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
      end
      s_out = s;
   endtask

   function automatic logic [NC-1:0] bank_board(input logic b);
      logic [NC-1:0] r;
      for (int i = 0; i < NC; i++) r[i] = mem[{b, 6'(i)}];
      return r;
   endfunction

   task automatic load_mem(input logic b, input logic [NC-1:0] board);
      load_bank = b;
      load_board = board;
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic check_idle(input string name);
      chk({name, "_state"}, state_o, 3'd0);
      chk({name, "_busy"}, busy, 1'b0);
      chk({name, "_bank"}, cur_bank, exp_bank);
      chk({name, "_gen_count"}, gen_count, exp_gen);
   endtask

   task automatic run_gen(input logic [NC-1:0] board, input bit vb, input bit noise,
                          output logic [NC-1:0] r, output int sp, output int nw);
      int w;
      load_mem(exp_bank, board);
      w = wr_cnt;
      vblank = vb;
      if (noise) begin run = 1'b1; gen_tick = 1'b1; end
      step = 1'b1;
      @(negedge clk);
      step = 1'b0; gen_tick = 1'b0;
      sp = 0;
      while (state_o != 3'd4 && sp < 2000) begin
         if (noise && sp == 100) begin step = 1'b1; gen_tick = 1'b1; clear = 1'b1; seed = 1'b1; end
         else begin step = 1'b0; gen_tick = 1'b0; clear = 1'b0; seed = 1'b0; end
         @(negedge clk);
         sp++;
      end
      step = 1'b0; gen_tick = 1'b0; clear = 1'b0; seed = 1'b0; run = 1'b0;
      chk("gen_reach_swap_wait", state_o, 3'd4);
      if (!vb) begin
         repeat (3) begin
            @(negedge clk);
            chk("vblank_hold_state", state_o, 3'd4);
            chk("vblank_hold_bank", cur_bank, exp_bank);
         end
         vblank = 1'b1;
      end
      @(negedge clk);
      vblank = 1'b0;
      exp_bank = ~exp_bank;
      exp_gen = exp_gen + 16'd1;
      nw = wr_cnt - w;
      r = bank_board(exp_bank);
   endtask

   task automatic run_init(input bit c, input bit s, input logic [NC-1:0] prefill,
                           output logic [NC-1:0] r, output int sp, output int nw);
      int w;
      load_mem(~exp_bank, prefill);
      w = wr_cnt;
      vblank = 1'b1;
      clear = c; seed = s;
      @(negedge clk);
      clear = 1'b0; seed = 1'b0;
      sp = 0;
      while (state_o != 3'd4 && sp < 2000) begin
         @(negedge clk);
         sp++;
      end
      chk("init_reach_swap_wait", state_o, 3'd4);
      @(negedge clk);
      vblank = 1'b0;
      exp_bank = ~exp_bank;
      exp_gen = 16'd0;
      nw = wr_cnt - w;
      r = bank_board(exp_bank);
   endtask

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{cur: 64'h0000_0000_000E_0000, nxt: 64'h0000_0000_0404_0400}; // blinker
      tbl[1] = '{cur: 64'h0000_0000_0000_0083, nxt: 64'h0100_0000_0000_0101}; // toroidal wrap
      tbl[2] = '{cur: 64'h0000_0010_0000_0000, nxt: 64'h0000_0000_0000_0000}; // lone cell dies
      tbl[3] = '{cur: 64'h0000_0018_1800_0000, nxt: 64'h0000_0018_1800_0000}; // block is stable

      @(negedge clk);
      chk("rst_state", state_o, 3'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_bank", cur_bank, 1'b0);
      chk("rst_gen_count", gen_count, 16'd0);
      chk("rst_rd_en", rd_en, 1'b0);
      chk("rst_rd_addr", rd_addr, 7'd0);
      chk("rst_wr_en", wr_en, 1'b0);
      chk("rst_wr_addr", wr_addr, 7'd0);
      chk("rst_wr_data", wr_data, 1'b0);
      chk("rst_vga_valid", vga_valid, 1'b0);
      chk("rst_vga_data", vga_data, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check_idle("post_reset");

      for (int i = 0; i < 4; i++) begin
         run_gen(tbl[i].cur, 1'b1, 1'b0, res, span, nwr);
         chk("table_next_board", res, tbl[i].nxt);
         chk("table_span", span, 704);
         chk("table_writes", nwr, 64);
         check_idle("table_end");
      end

      for (int i = 0; i < 3; i++) begin
         rb = {$urandom, $urandom};
         run_gen(rb, (i != 1), (i == 2), res, span, nwr);
         chk("rand_next_board", res, life_model(rb));
         chk("rand_writes", nwr, 64);
         check_idle("rand_end");
         w0 = wr_cnt;
         repeat (5) @(negedge clk);
         chk("rand_stays_idle", state_o, 3'd0);
         chk("rand_no_extra_writes", wr_cnt - w0, 0);
      end

      // VGA contention during the first cell
      load_mem(exp_bank, tbl[0].cur);
      w0 = wr_cnt;
      vblank = 1'b1;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      span = 0; cell_cyc = 0; wr_seen = 1'b0;
      vq.delete();
      while (state_o != 3'd4 && span < 2000) begin
         chk("vga_valid", vga_valid, (span >= 1 && span <= 5));
         if (span >= 1 && span <= 5) chk("vga_data", vga_data, vq.pop_front());
         if (span == 6) chk("vga_data_hold", vga_data, 1'b1);
         if (!wr_seen) begin
            cell_cyc++;
            wr_seen = wr_en;
         end
         if (span < 5) begin
            vga_req = 1'b1;
            vga_addr = addrs[span];
            vq.push_back(mem[{exp_bank, addrs[span]}]);
            #1;
            chk("vga_rd_en", rd_en, 1'b1);
            chk("vga_rd_addr", rd_addr, {exp_bank, addrs[span]});
         end else begin
            vga_req = 1'b0;
         end
         @(negedge clk);
         span++;
      end
      chk("cont_reach_swap_wait", state_o, 3'd4);
      @(negedge clk);
      vblank = 1'b0;
      exp_bank = ~exp_bank;
      exp_gen = exp_gen + 16'd1;
      chk("cont_next_board", bank_board(exp_bank), tbl[0].nxt);
      chk("cont_writes", wr_cnt - w0, 64);
      chk("cont_span", span, 709);
      chk("cont_first_cell_cycles", cell_cyc, 16);
      check_idle("cont_end");

      // clear and seed together: clear wins
      run_init(1'b1, 1'b1, {NC{1'b1}}, res, span, nwr);
      chk("clear_board", res, 64'd0);
      chk("clear_writes", nwr, 64);
      chk("clear_span", span, 64);
      check_idle("clear_end");

      for (int i = 0; i < 2; i++) begin
         seed_model(lfsr_m, sb, lfsr_m);
         run_init(1'b0, 1'b1, ~sb, res, span, nwr);
         chk("seed_board", res, sb);
         chk("seed_writes", nwr, 64);
         check_idle("seed_end");
      end

      // reset in the middle of READ, then a clean pass
      rb = {$urandom, $urandom};
      load_mem(exp_bank, rb);
      vblank = 1'b1;
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (15) @(negedge clk);
      chk("pre_reset_state", state_o, 3'd1);
      reset = 1'b1;
      #1;
      chk("midrst_state", state_o, 3'd0);
      chk("midrst_bank", cur_bank, 1'b0);
      chk("midrst_gen_count", gen_count, 16'd0);
      chk("midrst_wr_en", wr_en, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      vblank = 1'b0;
      exp_bank = 1'b0;
      exp_gen = 16'd0;
      @(negedge clk);
      run_gen(rb, 1'b1, 1'b0, res, span, nwr);
      chk("post_rst_next_board", res, life_model(rb));
      chk("post_rst_span", span, 704);
      chk("post_rst_writes", nwr, 64);
      check_idle("post_rst_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
